// File: rtl/mu0_io_bridge.sv
// mu0_io_bridge: sits between the MU0 core memory port and system RAM.
// Accesses outside the 16-word I/O window pass straight through to RAM;
// accesses inside the window hit a TX FIFO, an RX holding register, a
// status register and (optionally) a free-running cycle counter.
// Reads are combinational so the core can sample data in the same cycle
// it drives the address.
// Optional feature: define MU0_IO_CYCLE_COUNTER_EN to build the 16-bit
// cycle counter at offset +3; without it CYCLE reads 0 and ignores writes.
module mu0_io_bridge #(
  parameter logic [11:0] IO_BASE    = 12'hFF0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [15:0] cpu_rdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_strobe
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_RXDATA = 4'h2;
  localparam logic [3:0] OFF_CYCLE  = 4'h3;

  // Address decode and per-register access strobes
  logic       io_sel;
  logic [3:0] offset;
  logic       push_req;
  logic       status_wr;
  logic       rxdata_rd;

  assign io_sel    = (cpu_address[11:4] == IO_BASE[11:4]);
  assign offset    = cpu_address[3:0];
  assign push_req  = cpu_write & io_sel & (offset == OFF_TXDATA);
  assign status_wr = cpu_write & io_sel & (offset == OFF_STATUS);
  assign rxdata_rd = cpu_read  & io_sel & (offset == OFF_RXDATA);

  // RAM side: RAM never sees a write while reset is held
  assign mem_read  = cpu_read  & ~io_sel;
  assign mem_write = cpu_write & ~io_sel & rst;

  // TX FIFO storage and bookkeeping
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          tx_empty;
  logic          tx_full;
  logic          pop;
  logic          push_accept;
  logic          push_drop;

  assign tx_empty    = (count == '0);
  assign tx_full     = (count == DEPTH_C);
  assign tx_valid    = ~tx_empty;
  assign tx_data     = fifo_mem[rd_ptr];
  assign pop         = tx_valid & tx_ready;
  // A push into a full FIFO still fits if the head leaves on the same edge
  assign push_accept = push_req & (~tx_full | pop);
  assign push_drop   = push_req & tx_full & ~pop;

  // FIFO data array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_accept) begin
      fifo_mem[wr_ptr] <= cpu_wdata;
    end
  end

  // FIFO pointers and occupancy; reset discards any queued words
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // RX holding register; loads on every strobe, no backpressure
  logic [15:0] rx_hold;

  always_ff @(posedge clk) begin
    if (rx_strobe) begin
      rx_hold <= rx_data;
    end
  end

  // Sticky status flags; a new set event beats a same-cycle W1C clear
  logic rx_full;
  logic rx_overrun;
  logic tx_drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (rx_strobe) begin
        rx_full <= 1'b1;
      end else if (rxdata_rd) begin
        rx_full <= 1'b0;
      end

      if (rx_strobe & rx_full & ~rxdata_rd) begin
        rx_overrun <= 1'b1;
      end else if (status_wr & cpu_wdata[3]) begin
        rx_overrun <= 1'b0;
      end

      if (push_drop) begin
        tx_drop <= 1'b1;
      end else if (status_wr & cpu_wdata[4]) begin
        tx_drop <= 1'b0;
      end
    end
  end

  logic [15:0] cycle_value;

`ifdef MU0_IO_CYCLE_COUNTER_EN
  logic        cycle_wr;
  logic [15:0] cycle_count;

  assign cycle_wr    = cpu_write & io_sel & (offset == OFF_CYCLE);
  assign cycle_value = cycle_count;

  // Free-running cycle counter; a CPU write replaces that edge's increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_count <= 16'h0000;
    end else if (cycle_wr) begin
      cycle_count <= cpu_wdata;
    end else begin
      cycle_count <= cycle_count + 16'h0001;
    end
  end
`else
  assign cycle_value = 16'h0000;
`endif

  // Read mux: RAM outside the window, mapped registers inside it
  always_comb begin
    cpu_rdata = 16'h0000;
    if (!io_sel) begin
      cpu_rdata = mem_rdata;
    end else begin
      case (offset)
        OFF_STATUS: cpu_rdata = {11'b0, tx_drop, rx_overrun, rx_full, tx_full, tx_empty};
        OFF_RXDATA: cpu_rdata = rx_hold;
        OFF_CYCLE:  cpu_rdata = cycle_value;
        default:    cpu_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_io_bridge.sv
// tb_mu0_io_bridge: directed scenarios followed by a randomized phase, with
// every cycle compared against a queue-based model of the bridge.
module tb_mu0_io_bridge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_strobe = 1'b0;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state
  logic [15:0] txq[$];
  bit          m_rx_full  = 1'b0;
  bit          m_ovr      = 1'b0;
  bit          m_drop     = 1'b0;
  bit          m_rx_known = 1'b0;
  logic [15:0] m_rx       = '0;
`ifdef MU0_IO_CYCLE_COUNTER_EN
  logic [15:0] m_cycle    = '0;
`endif

  always #5 clk = ~clk;

  mu0_io_bridge #(.IO_BASE(12'hFF0), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_address(cpu_address),
    .cpu_wdata  (cpu_wdata),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe)
  );

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] addr, input logic [15:0] wdata,
                               input logic rd, input logic wr);
    cpu_address = addr;
    cpu_wdata   = wdata;
    cpu_read    = rd;
    cpu_write   = wr;
  endtask

  function automatic logic [15:0] modelRdata();
    if (cpu_address[11:4] != 8'hFF) return mem_rdata;
    case (cpu_address[3:0])
      4'h1: return {11'b0, m_drop, m_ovr, m_rx_full, txq.size() == DEPTH, txq.size() == 0};
      4'h2: return m_rx;
`ifdef MU0_IO_CYCLE_COUNTER_EN
      4'h3: return m_cycle;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Compare every output against the model for the current inputs
  task automatic checkOutput();
    bit io;
    io = (cpu_address[11:4] == 8'hFF);
    checkEq("mem_read", 16'(mem_read), 16'(cpu_read & ~io));
    checkEq("mem_write", 16'(mem_write), 16'(cpu_write & ~io & rst));
    if (!(io && cpu_address[3:0] == 4'h2 && !m_rx_known))
      checkEq("cpu_rdata", cpu_rdata, modelRdata());
    checkEq("tx_valid", 16'(tx_valid), 16'(txq.size() > 0));
    if (txq.size() > 0) checkEq("tx_data", tx_data, txq[0]);
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic modelStep();
    bit io, push, stw, rxrd, pop, was_full, drop_set, ovr_set;
    io = (cpu_address[11:4] == 8'hFF);
    if (!rst) begin
      txq.delete();
      m_rx_full  = 1'b0;
      m_ovr      = 1'b0;
      m_drop     = 1'b0;
      m_rx_known = 1'b0;
`ifdef MU0_IO_CYCLE_COUNTER_EN
      m_cycle    = 16'h0000;
`endif
    end else begin
      push     = cpu_write && io && cpu_address[3:0] == 4'h0;
      stw      = cpu_write && io && cpu_address[3:0] == 4'h1;
      rxrd     = cpu_read  && io && cpu_address[3:0] == 4'h2;
      was_full = (txq.size() == DEPTH);
      pop      = (txq.size() > 0) && tx_ready;
      drop_set = 1'b0;
      if (pop) void'(txq.pop_front());
      if (push) begin
        if (was_full && !pop) drop_set = 1'b1;
        else txq.push_back(cpu_wdata);
      end
      if (drop_set) m_drop = 1'b1;
      else if (stw && cpu_wdata[4]) m_drop = 1'b0;
      ovr_set = rx_strobe && m_rx_full && !rxrd;
      if (ovr_set) m_ovr = 1'b1;
      else if (stw && cpu_wdata[3]) m_ovr = 1'b0;
      if (rx_strobe) begin
        m_rx       = rx_data;
        m_rx_full  = 1'b1;
        m_rx_known = 1'b1;
      end else if (rxrd) begin
        m_rx_full = 1'b0;
      end
`ifdef MU0_IO_CYCLE_COUNTER_EN
      if (cpu_write && io && cpu_address[3:0] == 4'h3) m_cycle = cpu_wdata;
      else m_cycle = m_cycle + 16'h0001;
`endif
    end
  endtask

  task automatic cycle();
    #3;
    checkOutput();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input logic [11:0] addr, input logic [15:0] exp, input string tag);
    applyStimulus(addr, 16'h0000, 1'b1, 1'b0);
    #2;
    checkEq(tag, cpu_rdata, exp);
    cycle();
  endtask

  initial begin
    logic [15:0] pop_exp [4];
    int          off;

    // Reset with a RAM write held on the bus
    rst = 1'b0;
    applyStimulus(12'h010, 16'h1234, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    #2;
    checkEq("rst_mem_write", 16'(mem_write), 16'h0000);
    checkEq("rst_tx_valid", 16'(tx_valid), 16'h0000);
    cycle();
    cycle();
    rst = 1'b1;
    readCheck(12'hFF1, 16'h0001, "reset_status");

    // RAM passthrough and blocked RAM write to the window
    mem_rdata = 16'hBEEF;
    applyStimulus(12'h123, 16'h0000, 1'b1, 1'b0);
    #2;
    checkEq("pass_mem_read", 16'(mem_read), 16'h0001);
    readCheck(12'h123, 16'hBEEF, "pass_rdata");
    applyStimulus(12'hFF0, 16'h0777, 1'b0, 1'b1);
    #2;
    checkEq("io_mem_write", 16'(mem_write), 16'h0000);
    cycle();
    applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
    tx_ready = 1'b1;
    #2;
    checkEq("single_tx", tx_data, 16'h0777);
    cycle();
    tx_ready = 1'b0;

    // Fill TX with the sink stalled; fifth word drops
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(12'hFF0, 16'(i * 16'h0011), 1'b0, 1'b1);
      cycle();
    end
    readCheck(12'hFF1, 16'h0012, "fill_status");
    applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #2;
      checkEq("drain_data", tx_data, 16'(i * 16'h0011));
      cycle();
    end
    #2;
    checkEq("drain_empty", 16'(tx_valid), 16'h0000);
    applyStimulus(12'hFF1, 16'h0010, 1'b0, 1'b1);
    cycle();
    readCheck(12'hFF1, 16'h0001, "drop_cleared");

    // Push into a full FIFO on the same edge as a pop
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(12'hFF0, 16'(i * 16'h0011), 1'b0, 1'b1);
      cycle();
    end
    tx_ready = 1'b1;
    applyStimulus(12'hFF0, 16'h0066, 1'b0, 1'b1);
    cycle();
    applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
    pop_exp = '{16'h0022, 16'h0033, 16'h0044, 16'h0066};
    for (int i = 0; i < 4; i++) begin
      #2;
      checkEq("fullpop_data", tx_data, pop_exp[i]);
      cycle();
    end
    readCheck(12'hFF1, 16'h0001, "fullpop_status");
    tx_ready = 1'b0;

    // RX overrun, read-to-clear and W1C of overrun
    applyStimulus(12'h000, 16'h0000, 1'b0, 1'b0);
    rx_strobe = 1'b1;
    rx_data   = 16'hA5A5;
    cycle();
    rx_data   = 16'h5A5A;
    cycle();
    rx_strobe = 1'b0;
    readCheck(12'hFF1, 16'h000D, "rx_ovr_status");
    readCheck(12'hFF2, 16'h5A5A, "rx_data");
    readCheck(12'hFF1, 16'h0009, "rx_read_clears_full");
    applyStimulus(12'hFF1, 16'h0008, 1'b0, 1'b1);
    cycle();
    readCheck(12'hFF1, 16'h0001, "rx_ovr_cleared");

    // Cycle counter load and wrap
    applyStimulus(12'hFF3, 16'hFFFE, 1'b0, 1'b1);
    cycle();
`ifdef MU0_IO_CYCLE_COUNTER_EN
    readCheck(12'hFF3, 16'hFFFE, "cycle_0");
    readCheck(12'hFF3, 16'hFFFF, "cycle_1");
    readCheck(12'hFF3, 16'h0000, "cycle_2");
`else
    readCheck(12'hFF3, 16'h0000, "cycle_0");
    readCheck(12'hFF3, 16'h0000, "cycle_1");
    readCheck(12'hFF3, 16'h0000, "cycle_2");
`endif

    // Randomized traffic against the model
    $display("[TB] starting randomized phase");
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      tx_ready  = ($urandom_range(0, 2) == 0);
      rx_strobe = ($urandom_range(0, 3) == 0);
      rx_data   = 16'($urandom);
      mem_rdata = 16'($urandom);
      off       = $urandom_range(0, 5);
      if ($urandom_range(0, 3) != 0)
        cpu_address = {8'hFF, (off == 5) ? 4'($urandom) : 4'(off)};
      else
        cpu_address = 12'($urandom);
      cpu_wdata = 16'($urandom);
      case ($urandom_range(0, 2))
        0: begin cpu_read = 1'b0; cpu_write = 1'b0; end
        1: begin cpu_read = 1'b1; cpu_write = 1'b0; end
        default: begin cpu_read = 1'b0; cpu_write = 1'b1; end
      endcase
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
